prga: RTL and testbench



---
 rtl/arc4_pkg.sv | 25 ++
 rtl/prga_if.sv | 28 ++
 rtl/prga.sv | 201 ++++++++++++++++++++
 tb/tb_prga.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/arc4_pkg.sv
// Shared ARC4 definitions: byte type, memory layout constants and the
// PRGA state encoding used by the pseudo-random generation stage.
package arc4_pkg;

  typedef logic [7:0] byte_t;

  // ct[0] / pt[0] hold the message length; the message follows it.
  localparam byte_t LEN_ADDR    = 8'd0;
  localparam int    MSG_MAX_LEN = 255;

  typedef enum logic [3:0] {
    PRGA_IDLE   = 4'd0,
    PRGA_RD_LEN = 4'd1,
    PRGA_WR_LEN = 4'd2,
    PRGA_RD_SI  = 4'd3,
    PRGA_CALC_J = 4'd4,
    PRGA_RD_SJ  = 4'd5,
    PRGA_CAP_SJ = 4'd6,
    PRGA_WR_I   = 4'd7,
    PRGA_WR_J   = 4'd8,
    PRGA_RD_PAD = 4'd9,
    PRGA_WR_PT  = 4'd10
  } prga_state_e;

endpackage

// File: rtl/prga_if.sv
// Start handshake plus the S, ciphertext and plaintext memory buses of the
// PRGA stage. master = the PRGA engine, slave = memories / controller.
interface prga_if;
  import arc4_pkg::*;

  logic  en;
  logic  rdy;
  byte_t s_addr;
  byte_t s_rddata;
  byte_t s_wrdata;
  logic  s_wren;
  byte_t ct_addr;
  byte_t ct_rddata;
  byte_t pt_addr;
  byte_t pt_wrdata;
  logic  pt_wren;

  modport master (
    input  en, s_rddata, ct_rddata,
    output rdy, s_addr, s_wrdata, s_wren, ct_addr, pt_addr, pt_wrdata, pt_wren
  );

  modport slave (
    output en, s_rddata, ct_rddata,
    input  rdy, s_addr, s_wrdata, s_wren, ct_addr, pt_addr, pt_wrdata, pt_wren
  );

endinterface

// File: rtl/prga.sv
// ARC4 pseudo-random generation and decryption. Walks the permuted S-box,
// swaps S[i]/S[j] per byte and XORs the pad byte with the ciphertext.
// Memory addresses and write enables are registered: each is loaded on the
// edge entering the state that presents it, so read data comes back in the
// following state. Plaintext writes depend on read data, so they are
// registered on leaving WR_LEN / WR_PT and land one cycle later.
module prga
  import arc4_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  prga_if.master    bus
);

  prga_state_e state, state_n;

  logic  rdy, rdy_n;
  byte_t s_addr, s_addr_n;
  byte_t s_wrdata, s_wrdata_n;
  logic  s_wren, s_wren_n;
  byte_t ct_addr, ct_addr_n;
  byte_t pt_addr, pt_addr_n;
  byte_t pt_wrdata, pt_wrdata_n;
  logic  pt_wren, pt_wren_n;

  byte_t i, i_n;
  byte_t j, j_n;
  byte_t k, k_n;
  byte_t len, len_n;

  // Datapath captures; only meaningful while a message is in flight.
  byte_t si, sj, c;
  logic  si_ld, sj_ld;

  assign bus.rdy       = rdy;
  assign bus.s_addr    = s_addr;
  assign bus.s_wrdata  = s_wrdata;
  assign bus.s_wren    = s_wren;
  assign bus.ct_addr   = ct_addr;
  assign bus.pt_addr   = pt_addr;
  assign bus.pt_wrdata = pt_wrdata;
  assign bus.pt_wren   = pt_wren;

  // State, control and registered memory-port outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= PRGA_IDLE;
      rdy       <= 1'b0;
      s_addr    <= '0;
      s_wrdata  <= '0;
      s_wren    <= 1'b0;
      ct_addr   <= '0;
      pt_addr   <= '0;
      pt_wrdata <= '0;
      pt_wren   <= 1'b0;
      i         <= '0;
      j         <= '0;
      k         <= '0;
      len       <= '0;
    end else begin
      state     <= state_n;
      rdy       <= rdy_n;
      s_addr    <= s_addr_n;
      s_wrdata  <= s_wrdata_n;
      s_wren    <= s_wren_n;
      ct_addr   <= ct_addr_n;
      pt_addr   <= pt_addr_n;
      pt_wrdata <= pt_wrdata_n;
      pt_wren   <= pt_wren_n;
      i         <= i_n;
      j         <= j_n;
      k         <= k_n;
      len       <= len_n;
    end
  end

  // Capture S[i], S[j] and the ciphertext byte as they come back from memory.
  always_ff @(posedge clk) begin
    if (si_ld) begin
      si <= bus.s_rddata;
      c  <= bus.ct_rddata;
    end
    if (sj_ld) begin
      sj <= bus.s_rddata;
    end
  end

  // Next-state and next-output decode; values are those of the state entered.
  always_comb begin
    state_n     = state;
    rdy_n       = rdy;
    s_addr_n    = s_addr;
    s_wrdata_n  = s_wrdata;
    s_wren_n    = 1'b0;
    ct_addr_n   = ct_addr;
    pt_addr_n   = pt_addr;
    pt_wrdata_n = pt_wrdata;
    pt_wren_n   = 1'b0;
    i_n         = i;
    j_n         = j;
    k_n         = k;
    len_n       = len;
    si_ld       = 1'b0;
    sj_ld       = 1'b0;

    case (state)
      PRGA_IDLE: begin
        rdy_n = 1'b1;
        if (rdy && bus.en) begin
          rdy_n     = 1'b0;
          ct_addr_n = LEN_ADDR;
          i_n       = 8'd0;
          j_n       = 8'd0;
          k_n       = 8'd1;
          state_n   = PRGA_RD_LEN;
        end
      end

      PRGA_RD_LEN: begin
        state_n = PRGA_WR_LEN;
      end

      PRGA_WR_LEN: begin
        len_n       = bus.ct_rddata;
        pt_addr_n   = LEN_ADDR;
        pt_wrdata_n = bus.ct_rddata;
        pt_wren_n   = 1'b1;
        if (bus.ct_rddata == 8'd0) begin
          rdy_n   = 1'b1;
          state_n = PRGA_IDLE;
        end else begin
          i_n       = 8'd1;
          s_addr_n  = 8'd1;
          ct_addr_n = k;
          state_n   = PRGA_RD_SI;
        end
      end

      PRGA_RD_SI: begin
        state_n = PRGA_CALC_J;
      end

      PRGA_CALC_J: begin
        si_ld    = 1'b1;
        j_n      = j + bus.s_rddata;
        s_addr_n = j + bus.s_rddata;
        state_n  = PRGA_RD_SJ;
      end

      PRGA_RD_SJ: begin
        state_n = PRGA_CAP_SJ;
      end

      PRGA_CAP_SJ: begin
        sj_ld      = 1'b1;
        s_addr_n   = i;
        s_wrdata_n = bus.s_rddata;
        s_wren_n   = 1'b1;
        state_n    = PRGA_WR_I;
      end

      PRGA_WR_I: begin
        s_addr_n   = j;
        s_wrdata_n = si;
        s_wren_n   = 1'b1;
        state_n    = PRGA_WR_J;
      end

      PRGA_WR_J: begin
        s_addr_n = si + sj;
        state_n  = PRGA_RD_PAD;
      end

      PRGA_RD_PAD: begin
        state_n = PRGA_WR_PT;
      end

      PRGA_WR_PT: begin
        pt_addr_n   = k;
        pt_wrdata_n = bus.s_rddata ^ c;
        pt_wren_n   = 1'b1;
        if (k == len) begin
          rdy_n   = 1'b1;
          state_n = PRGA_IDLE;
        end else begin
          k_n       = k + 8'd1;
          i_n       = i + 8'd1;
          s_addr_n  = i + 8'd1;
          ct_addr_n = k + 8'd1;
          state_n   = PRGA_RD_SI;
        end
      end

      default: begin
        rdy_n   = 1'b0;
        state_n = PRGA_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_prga.sv
// Directed bench for the ARC4 PRGA stage with behavioural S/ct/pt memories.
module tb_prga;
  import arc4_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  prga_if bus();

  prga dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  byte_t s_mem  [256];
  byte_t ct_mem [256];
  byte_t pt_mem [256];

  logic       ld_we = 1'b0;
  logic [1:0] ld_sel = 2'd0;
  byte_t      ld_addr = 8'd0;
  byte_t      ld_data = 8'd0;

  // Synchronous-read memories; the bench loads them through a side port.
  always @(posedge clk) begin
    if (bus.s_wren) s_mem[bus.s_addr] <= bus.s_wrdata;
    else if (ld_we && ld_sel == 2'd0) s_mem[ld_addr] <= ld_data;
    bus.s_rddata <= s_mem[bus.s_addr];
    if (ld_we && ld_sel == 2'd1) ct_mem[ld_addr] <= ld_data;
    bus.ct_rddata <= ct_mem[bus.ct_addr];
    if (bus.pt_wren) pt_mem[bus.pt_addr] <= bus.pt_wrdata;
    else if (ld_we && ld_sel == 2'd2) pt_mem[ld_addr] <= ld_data;
  end

  int   s_wr_cnt = 0;
  int   pt_wr_cnt = 0;
  int   ovl_cnt = 0;
  int   starts = 0;
  logic prev_rdy = 1'b0;

  // Activity monitor sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.s_wren === 1'b1) s_wr_cnt <= s_wr_cnt + 1;
    if (bus.pt_wren === 1'b1) pt_wr_cnt <= pt_wr_cnt + 1;
    if (bus.s_wren === 1'b1 && bus.pt_wren === 1'b1) ovl_cnt <= ovl_cnt + 1;
    if (prev_rdy === 1'b1 && bus.rdy === 1'b0) starts <= starts + 1;
    prev_rdy <= bus.rdy;
  end

  int n_assert = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic poke(input int sel, input int a, input int d);
    ld_sel  = sel[1:0];
    ld_addr = a[7:0];
    ld_data = d[7:0];
    ld_we   = 1'b1;
    @(posedge clk);
    #1 ld_we = 1'b0;
  endtask

  task automatic load_identity();
    for (int x = 0; x < 256; x++) poke(0, x, x);
  endtask

  // Software ARC4 model over a snapshot of the current memories.
  byte_t ms     [256];
  byte_t exp_pt [256];
  task automatic model_run();
    byte_t mi, mj, t, ml;
    for (int x = 0; x < 256; x++) ms[x] = s_mem[x];
    ml = ct_mem[0];
    exp_pt[0] = ml;
    mi = 8'd0;
    mj = 8'd0;
    for (int x = 1; x <= int'(ml); x++) begin
      mi = mi + 8'd1;
      mj = mj + ms[mi];
      t = ms[mi]; ms[mi] = ms[mj]; ms[mj] = t;
      t = ms[mi] + ms[mj];
      exp_pt[x] = ct_mem[x] ^ ms[t];
    end
  endtask

  // Pulse en once rdy is high, then count cycles with rdy low.
  task automatic run_msg(input string tag, output int low);
    int w;
    w = 0;
    @(negedge clk);
    while (bus.rdy !== 1'b1 && w < 20) begin
      w++;
      @(negedge clk);
    end
    chk({tag, "_rdy_before"}, bus.rdy, 1'b1);
    bus.en = 1'b1;
    @(negedge clk);
    bus.en = 1'b0;
    low = 0;
    while (bus.rdy === 1'b0 && low < 5000) begin
      low++;
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int    low, bad, sw0, pw0, ov0, st0;
    byte_t key [3];
    byte_t kj, kt;

    bus.en = 1'b0;

    // Reset values while rst_n is held low.
    #2;
    chk("reset_rdy", bus.rdy, 1'b0);
    chk("reset_outputs",
        {bus.s_addr, bus.s_wrdata, bus.s_wren, bus.ct_addr, bus.pt_addr, bus.pt_wrdata, bus.pt_wren},
        43'd0);
    load_identity();
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("release_rdy_low", bus.rdy, 1'b0);
    @(posedge clk);
    #1 chk("release_rdy_high", bus.rdy, 1'b1);

    // One byte, identity S: i=j=1, pad=S[2]=2.
    poke(1, 0, 8'h01); poke(1, 1, 8'h41);
    poke(2, 0, 8'hEE); poke(2, 1, 8'hEE);
    sw0 = s_wr_cnt; pw0 = pt_wr_cnt; ov0 = ovl_cnt;
    run_msg("t1", low);
    chk("t1_latency", low, 10);
    chk("t1_pt0", pt_mem[0], 8'h01);
    chk("t1_pt1", pt_mem[1], 8'h43);
    bad = 0;
    for (int x = 0; x < 256; x++) if (s_mem[x] !== byte_t'(x)) bad++;
    chk("t1_s_unchanged", bad, 0);
    chk("t1_s_writes", s_wr_cnt - sw0, 2);
    chk("t1_pt_writes", pt_wr_cnt - pw0, 2);

    // Two bytes: second byte swaps S[2]/S[3], pad=S[5]=5.
    poke(1, 0, 8'h02); poke(1, 1, 8'h41); poke(1, 2, 8'h00);
    poke(2, 0, 8'hEE); poke(2, 1, 8'hEE); poke(2, 2, 8'hEE);
    run_msg("t2", low);
    chk("t2_latency", low, 18);
    chk("t2_pt0", pt_mem[0], 8'h02);
    chk("t2_pt1", pt_mem[1], 8'h43);
    chk("t2_pt2", pt_mem[2], 8'h05);
    chk("t2_s2", s_mem[2], 8'h03);
    chk("t2_s3", s_mem[3], 8'h02);
    bad = 0;
    for (int x = 0; x < 256; x++)
      if (x != 2 && x != 3 && s_mem[x] !== byte_t'(x)) bad++;
    chk("t2_s_rest", bad, 0);

    // Empty message: only pt[0] written, no S traffic.
    poke(1, 0, 8'h00);
    poke(2, 0, 8'hEE);
    sw0 = s_wr_cnt; pw0 = pt_wr_cnt;
    run_msg("t3", low);
    chk("t3_latency", low, 2);
    chk("t3_pt0", pt_mem[0], 8'h00);
    chk("t3_s_writes", s_wr_cnt - sw0, 0);
    chk("t3_pt_writes", pt_wr_cnt - pw0, 1);

    // Full-length message over an S permuted by KSA with key 00_00_18.
    key[0] = 8'h00; key[1] = 8'h00; key[2] = 8'h18;
    for (int x = 0; x < 256; x++) ms[x] = byte_t'(x);
    kj = 8'd0;
    for (int x = 0; x < 256; x++) begin
      kj = kj + ms[x] + key[x % 3];
      kt = ms[x]; ms[x] = ms[kj]; ms[kj] = kt;
    end
    for (int x = 0; x < 256; x++) poke(0, x, ms[x]);
    poke(1, 0, 255);
    for (int x = 1; x < 256; x++) poke(1, x, $urandom_range(0, 255));
    model_run();
    sw0 = s_wr_cnt; ov0 = ovl_cnt;
    run_msg("t4", low);
    chk("t4_latency", low, 2 + 8 * 255);
    for (int x = 0; x < 256; x++) chk($sformatf("t4_pt%0d", x), pt_mem[x], exp_pt[x]);
    bad = 0;
    for (int x = 0; x < 256; x++) if (s_mem[x] !== ms[x]) bad++;
    chk("t4_s_final", bad, 0);
    chk("t4_s_writes", s_wr_cnt - sw0, 2 * 255);
    chk("t4_wren_overlap", ovl_cnt - ov0, 0);

    // en held high through a run, with a glitch mid-run: one message only.
    poke(1, 0, 3); poke(1, 1, 8'h10); poke(1, 2, 8'h20); poke(1, 3, 8'h30);
    model_run();
    st0 = starts;
    @(negedge clk);
    bus.en = 1'b1;
    @(negedge clk);
    low = 0;
    while (bus.rdy === 1'b0 && low < 5000) begin
      low++;
      if (low == 10) bus.en = 1'b0;
      if (low == 11) bus.en = 1'b1;
      @(negedge clk);
    end
    bus.en = 1'b0;
    chk("t5_latency", low, 26);
    repeat (3) @(negedge clk);
    chk("t5_rdy_stays", bus.rdy, 1'b1);
    chk("t5_starts", starts - st0, 1);
    for (int x = 0; x < 4; x++) chk($sformatf("t5_pt%0d", x), pt_mem[x], exp_pt[x]);

    // Reset 20 cycles into a run.
    poke(1, 0, 5);
    @(negedge clk);
    bus.en = 1'b1;
    @(negedge clk);
    bus.en = 1'b0;
    repeat (19) @(negedge clk);
    chk("t6_busy_before_reset", bus.rdy, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("t6_reset_rdy", bus.rdy, 1'b0);
    chk("t6_reset_outputs",
        {bus.s_addr, bus.s_wrdata, bus.s_wren, bus.ct_addr, bus.pt_addr, bus.pt_wrdata, bus.pt_wren},
        43'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1 chk("t6_release_rdy_low", bus.rdy, 1'b0);
    @(posedge clk);
    #1 chk("t6_release_rdy_high", bus.rdy, 1'b1);
    load_identity();
    poke(1, 0, 8'h01); poke(1, 1, 8'h41);
    poke(2, 0, 8'hEE); poke(2, 1, 8'hEE);
    run_msg("t6", low);
    chk("t6_latency", low, 10);
    chk("t6_pt0", pt_mem[0], 8'h01);
    chk("t6_pt1", pt_mem[1], 8'h43);
    chk("t6_wren_overlap_total", ovl_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
